// File: rtl/pheap_level_n.sv
// -----------------------------------------------------------------------------
// pheap_level_n
//
// Per-level controller for the pipelined heap, used at level 2 and below.
// Each node has K = 2^ARITY_LOG2 children. The controller reads its node from
// this level's memory (rTop) and the node's whole child row from the next
// level's memory (rBot). It then rewrites the node and forwards at most one
// operation to the level below.
//
// Entry layout: {active, capacity[CW], key[KW], value[VW]}
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start, op     request (00 NOP, 01 ENQ, 10 DEQ, 11 REPLACE), taken when ready
//   startPos      node index at this level
//   in_kv         key/value carried in with the request
//   rTop          this level's entry, valid the cycle after raddrTop
//   rBot          K child entries from the next level, child i at [i*EW +: EW]
//   next_ready    level below accepts the forwarded operation
//   ready         idle, start accepted
//   active        start pending or controller busy
//   done          00 DONE, 01 WAIT, 10 NEXT_LEVEL
//   raddrTop      top read address
//   wraddrTop     top write address
//   raddrBot      base of the child row, {pos, 0}
//   wenTop, wData top write enable / data
//   out_kv        displaced or dequeued item
//   out_op        operation forwarded downstream
//   endPos        child index the forwarded operation targets
//   ovf, udf      one-cycle overflow / underflow pulses
// -----------------------------------------------------------------------------
module pheap_level_n #(
    parameter int LEVEL      = 2,
    parameter int ARITY_LOG2 = 1,
    parameter int KW         = 16,
    parameter int VW         = 16,
    parameter int CW         = 8,
    parameter int MIN_HEAP   = 0,
    localparam int K  = 1 << ARITY_LOG2,
    localparam int PW = (LEVEL - 1) * ARITY_LOG2,
    localparam int EW = 1 + CW + KW + VW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [PW-1:0]          startPos,
    input  logic [KW+VW-1:0]       in_kv,
    input  logic [EW-1:0]          rTop,
    input  logic [K*EW-1:0]        rBot,
    input  logic                   next_ready,
    output logic                   ready,
    output logic                   active,
    output logic [1:0]             done,
    output logic [PW-1:0]          raddrTop,
    output logic [PW-1:0]          wraddrTop,
    output logic [PW+ARITY_LOG2-1:0] raddrBot,
    output logic                   wenTop,
    output logic [EW-1:0]          wData,
    output logic [KW+VW-1:0]       out_kv,
    output logic [1:0]             out_op,
    output logic [PW+ARITY_LOG2-1:0] endPos,
    output logic                   ovf,
    output logic                   udf
);

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ENQ = 2'b01;
    localparam logic [1:0] OP_DEQ = 2'b10;
    localparam logic [1:0] OP_REP = 2'b11;

    localparam logic [1:0] DONE_DONE = 2'b00;
    localparam logic [1:0] DONE_WAIT = 2'b01;
    localparam logic [1:0] DONE_NEXT = 2'b10;

    localparam logic [CW-1:0] CAP_ZERO = '0;
    localparam logic [CW-1:0] CAP_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CAP_FULL = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EVAL = 2'b01,
        S_SEND = 2'b10
    } state_t;

    state_t state_reg, state_next;

    logic [PW-1:0]             pos_reg;
    logic [KW+VW-1:0]          kv_reg;
    logic [1:0]                op_reg;
    logic [KW+VW-1:0]          out_kv_reg, out_kv_next;
    logic [1:0]                out_op_reg, out_op_next;
    logic [PW+ARITY_LOG2-1:0]  end_pos_reg, end_pos_next;

    // A request is taken only from IDLE and never while reset is applied.
    logic accept;
    assign accept = (state_reg == S_IDLE) && start && (op != OP_NOP) && !rst;

    // "better" is strict: equal keys never win, so ties keep the incumbent.
    function automatic logic better(input logic [KW-1:0] a, input logic [KW-1:0] b);
        if (MIN_HEAP != 0)
            return a < b;
        else
            return a > b;
    endfunction

    // ------------------------------------------------------------------
    // Field decode of the top entry and of each child entry
    // ------------------------------------------------------------------
    logic              top_act;
    logic [CW-1:0]     top_cap;
    logic [KW-1:0]     top_key;
    logic [KW+VW-1:0]  top_kv;
    logic [KW-1:0]     kv_key;
    logic [CW-1:0]     cap_inc, cap_dec;

    assign top_act = rTop[EW-1];
    assign top_cap = rTop[KW+VW +: CW];
    assign top_key = rTop[VW +: KW];
    assign top_kv  = rTop[KW+VW-1:0];
    assign kv_key  = kv_reg[VW +: KW];

    // Capacity arithmetic saturates in both directions.
    assign cap_inc = (top_cap == CAP_FULL) ? CAP_FULL : top_cap + CAP_ONE;
    assign cap_dec = (top_cap == CAP_ZERO) ? CAP_ZERO : top_cap - CAP_ONE;

    logic [K-1:0]      child_act;
    logic [CW-1:0]     child_cap [K];
    logic [KW-1:0]     child_key [K];
    logic [KW+VW-1:0]  child_kv  [K];

    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_child
            assign child_act[gi] = rBot[gi*EW + EW - 1];
            assign child_cap[gi] = rBot[gi*EW + KW + VW +: CW];
            assign child_key[gi] = rBot[gi*EW + VW +: KW];
            assign child_kv[gi]  = rBot[gi*EW +: KW+VW];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Child selection: largest capacity (for ENQ) and best active key
    // (for DEQ/REPLACE). Strict comparisons make the lowest index win ties.
    // ------------------------------------------------------------------
    logic [ARITY_LOG2-1:0] cap_idx;
    logic [CW-1:0]         cap_max;
    logic [ARITY_LOG2-1:0] best_idx;
    logic                  best_found;
    logic [KW-1:0]         best_key;
    logic [KW+VW-1:0]      best_kv;

    always_comb begin
        cap_idx    = '0;
        cap_max    = child_cap[0];
        best_idx   = '0;
        best_found = 1'b0;
        best_key   = '0;
        best_kv    = '0;
        for (int i = 1; i < K; i++) begin
            if (child_cap[i] > cap_max) begin
                cap_max = child_cap[i];
                cap_idx = i[ARITY_LOG2-1:0];
            end
        end
        for (int i = 0; i < K; i++) begin
            if (child_act[i] && (!best_found || better(child_key[i], best_key))) begin
                best_found = 1'b1;
                best_idx   = i[ARITY_LOG2-1:0];
                best_key   = child_key[i];
                best_kv    = child_kv[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // EVAL decision: what to write back, what to report, what to forward
    // ------------------------------------------------------------------
    logic             wen_eval;
    logic [EW-1:0]    wdata_eval;
    logic             ovf_eval, udf_eval, fwd_eval;

    always_comb begin
        wen_eval     = 1'b0;
        wdata_eval   = '0;
        ovf_eval     = 1'b0;
        udf_eval     = 1'b0;
        fwd_eval     = 1'b0;
        out_kv_next  = '0;
        out_op_next  = OP_NOP;
        end_pos_next = '0;
        case (op_reg)
            OP_DEQ: begin
                if (!top_act) begin
                    udf_eval = 1'b1;
                end else begin
                    out_kv_next = top_kv;
                    wen_eval    = 1'b1;
                    if (best_found) begin
                        // Pull the best child up; the hole moves down a level.
                        wdata_eval   = {1'b1, cap_inc, best_kv};
                        fwd_eval     = 1'b1;
                        out_op_next  = OP_DEQ;
                        end_pos_next = {pos_reg, best_idx};
                    end else begin
                        wdata_eval = {1'b0, cap_inc, {(KW+VW){1'b0}}};
                    end
                end
            end
            OP_ENQ, OP_REP: begin
                if (!top_act) begin
                    // Empty node: both ENQ and REPLACE simply fill it.
                    wen_eval   = 1'b1;
                    wdata_eval = {1'b1, cap_dec, kv_reg};
                end else if (op_reg == OP_ENQ) begin
                    if (top_cap == CAP_ZERO) begin
                        ovf_eval    = 1'b1;
                        out_kv_next = kv_reg;
                    end else begin
                        wen_eval     = 1'b1;
                        fwd_eval     = 1'b1;
                        out_op_next  = OP_ENQ;
                        end_pos_next = {pos_reg, cap_idx};
                        if (better(kv_key, top_key)) begin
                            wdata_eval  = {1'b1, cap_dec, kv_reg};
                            out_kv_next = top_kv;
                        end else begin
                            wdata_eval  = {1'b1, cap_dec, top_kv};
                            out_kv_next = kv_reg;
                        end
                    end
                end else begin
                    // REPLACE on an occupied node: out_kv reports the item
                    // leaving this node; capacity is unchanged.
                    out_kv_next = top_kv;
                    wen_eval    = 1'b1;
                    if (best_found && better(best_key, kv_key)) begin
                        wdata_eval   = {1'b1, top_cap, best_kv};
                        fwd_eval     = 1'b1;
                        out_op_next  = OP_REP;
                        end_pos_next = {pos_reg, best_idx};
                    end else begin
                        wdata_eval = {1'b1, top_cap, kv_reg};
                    end
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            pos_reg     <= '0;
            kv_reg      <= '0;
            op_reg      <= OP_NOP;
            out_kv_reg  <= '0;
            out_op_reg  <= OP_NOP;
            end_pos_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                pos_reg <= startPos;
                kv_reg  <= in_kv;
                op_reg  <= op;
            end
            if (state_reg == S_EVAL) begin
                out_kv_reg  <= out_kv_next;
                out_op_reg  <= out_op_next;
                end_pos_reg <= end_pos_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept) state_next = S_EVAL;
            S_EVAL: state_next = fwd_eval ? S_SEND : S_IDLE;
            S_SEND: if (next_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        ready     = (state_reg == S_IDLE);
        active    = start || (state_reg != S_IDLE);
        raddrTop  = pos_reg;
        raddrBot  = {pos_reg, {ARITY_LOG2{1'b0}}};
        wraddrTop = pos_reg;
        wenTop    = 1'b0;
        wData     = '0;
        ovf       = 1'b0;
        udf       = 1'b0;
        done      = DONE_DONE;
        case (state_reg)
            S_IDLE: begin
                raddrTop = startPos;
                raddrBot = {startPos, {ARITY_LOG2{1'b0}}};
                done     = accept ? DONE_WAIT : DONE_DONE;
            end
            S_EVAL: begin
                wenTop = wen_eval && !rst;
                wData  = (wen_eval && !rst) ? wdata_eval : '0;
                ovf    = ovf_eval && !rst;
                udf    = udf_eval && !rst;
                done   = fwd_eval ? DONE_WAIT : DONE_DONE;
            end
            S_SEND: begin
                done = DONE_NEXT;
            end
            default: ;
        endcase
    end

    assign out_kv = out_kv_reg;
    assign out_op = out_op_reg;
    assign endPos = end_pos_reg;

endmodule

// File: tb/tb_pheap_level_n.sv
module tb_pheap_level_n;

    localparam int LEVEL = 2;
    localparam int AL    = 2;
    localparam int KW    = 16;
    localparam int VW    = 16;
    localparam int CW    = 8;
    localparam int K     = 4;
    localparam int PW    = 2;
    localparam int EW    = 41;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              start_mx, start_mn;
    logic [1:0]        op;
    logic [PW-1:0]     startPos;
    logic [31:0]       in_kv;
    logic [EW-1:0]     rTop;
    logic [K*EW-1:0]   rBot;
    logic              next_ready;

    logic mx_ready, mx_active, mx_wen, mx_ovf, mx_udf;
    logic [1:0] mx_done, mx_out_op;
    logic [PW-1:0] mx_raddr, mx_wraddr;
    logic [PW+AL-1:0] mx_raddr_bot, mx_end_pos;
    logic [EW-1:0] mx_wdata;
    logic [31:0] mx_out_kv;

    logic mn_ready, mn_active, mn_wen, mn_ovf, mn_udf;
    logic [1:0] mn_done, mn_out_op;
    logic [PW-1:0] mn_raddr, mn_wraddr;
    logic [PW+AL-1:0] mn_raddr_bot, mn_end_pos;
    logic [EW-1:0] mn_wdata;
    logic [31:0] mn_out_kv;

    pheap_level_n #(.LEVEL(LEVEL), .ARITY_LOG2(AL), .KW(KW), .VW(VW), .CW(CW), .MIN_HEAP(0)) u_max (
        .clk(clk), .rst(rst), .start(start_mx), .op(op), .startPos(startPos), .in_kv(in_kv),
        .rTop(rTop), .rBot(rBot), .next_ready(next_ready),
        .ready(mx_ready), .active(mx_active), .done(mx_done), .raddrTop(mx_raddr),
        .wraddrTop(mx_wraddr), .raddrBot(mx_raddr_bot), .wenTop(mx_wen), .wData(mx_wdata),
        .out_kv(mx_out_kv), .out_op(mx_out_op), .endPos(mx_end_pos), .ovf(mx_ovf), .udf(mx_udf)
    );

    pheap_level_n #(.LEVEL(LEVEL), .ARITY_LOG2(AL), .KW(KW), .VW(VW), .CW(CW), .MIN_HEAP(1)) u_min (
        .clk(clk), .rst(rst), .start(start_mn), .op(op), .startPos(startPos), .in_kv(in_kv),
        .rTop(rTop), .rBot(rBot), .next_ready(next_ready),
        .ready(mn_ready), .active(mn_active), .done(mn_done), .raddrTop(mn_raddr),
        .wraddrTop(mn_wraddr), .raddrBot(mn_raddr_bot), .wenTop(mn_wen), .wData(mn_wdata),
        .out_kv(mn_out_kv), .out_op(mn_out_op), .endPos(mn_end_pos), .ovf(mn_ovf), .udf(mn_udf)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        wen;
        logic [40:0] wdata;
        logic        ovf;
        logic        udf;
        logic [1:0]  out_op;
        logic [3:0]  end_pos;
        logic        chk_kv;
        logic [31:0] out_kv;
    } exp_t;

    exp_t sb[$];

    function automatic logic [31:0] kv(input logic [15:0] key);
        return {key, key ^ 16'h1111};
    endfunction

    function automatic logic [40:0] mk(input logic a, input logic [7:0] c, input logic [31:0] k);
        return {a, c, k};
    endfunction

    function automatic exp_t ex(input logic wen, input logic [40:0] wdata, input logic ovf,
                                input logic udf, input logic [1:0] oop, input logic [3:0] ep,
                                input logic ck, input logic [31:0] okv);
        exp_t e;
        e.wen = wen; e.wdata = wdata; e.ovf = ovf; e.udf = udf;
        e.out_op = oop; e.end_pos = ep; e.chk_kv = ck; e.out_kv = okv;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        checks++;
        assert (obs === req)
        else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, req);
        end
    endtask

    // One operation through EVAL and into the following cycle.
    task automatic run_op(input string tag, input bit sel, input logic [1:0] o,
                          input logic [1:0] pos, input logic [31:0] k,
                          input logic [40:0] top, input logic [163:0] bot, input exp_t e);
        exp_t x;
        logic fwd;
        @(negedge clk);
        chk({tag, " ready"}, sel ? mn_ready : mx_ready, 1);
        op = o; startPos = pos; in_kv = k; rTop = top; rBot = bot;
        if (sel) start_mn = 1'b1; else start_mx = 1'b1;
        sb.push_back(e);
        #1;
        chk({tag, " raddrTop"}, sel ? mn_raddr : mx_raddr, pos);
        chk({tag, " raddrBot"}, sel ? mn_raddr_bot : mx_raddr_bot, {pos, 2'b00});
        chk({tag, " done0"}, sel ? mn_done : mx_done, 2'b01);
        @(negedge clk);
        start_mx = 1'b0; start_mn = 1'b0;
        x = sb.pop_front();
        fwd = (x.out_op != 2'b00);
        chk({tag, " wen"}, sel ? mn_wen : mx_wen, x.wen);
        if (x.wen) begin
            chk({tag, " wData"}, sel ? mn_wdata : mx_wdata, x.wdata);
            chk({tag, " wraddr"}, sel ? mn_wraddr : mx_wraddr, pos);
        end
        chk({tag, " ovf"}, sel ? mn_ovf : mx_ovf, x.ovf);
        chk({tag, " udf"}, sel ? mn_udf : mx_udf, x.udf);
        chk({tag, " done1"}, sel ? mn_done : mx_done, fwd ? 2'b01 : 2'b00);
        @(negedge clk);
        chk({tag, " wen2"}, sel ? mn_wen : mx_wen, 0);
        chk({tag, " ovf2"}, sel ? mn_ovf : mx_ovf, 0);
        chk({tag, " out_op"}, sel ? mn_out_op : mx_out_op, x.out_op);
        chk({tag, " done2"}, sel ? mn_done : mx_done, fwd ? 2'b10 : 2'b00);
        chk({tag, " ready2"}, sel ? mn_ready : mx_ready, !fwd);
        if (fwd) chk({tag, " endPos"}, sel ? mn_end_pos : mx_end_pos, x.end_pos);
        if (x.chk_kv) chk({tag, " out_kv"}, sel ? mn_out_kv : mx_out_kv, x.out_kv);
        $display("op %s: sel=%0d op=%0d pos=%0d kv=%h", tag, sel, o, pos, k);
    endtask

    // Release the downstream handshake and wait (bounded) for idle.
    task automatic wait_idle(input string tag, input bit sel);
        int n;
        next_ready = 1'b1;
        n = 0;
        while (!(sel ? mn_ready : mx_ready) && n < 6) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " idle"}, sel ? mn_ready : mx_ready, 1);
    endtask

    logic [163:0] bot_caps, bot_deq, bot_deq2, bot_empty;
    logic [31:0]  held_kv;

    initial begin
        rst = 1'b1; start_mx = 1'b0; start_mn = 1'b0; op = 2'b00; startPos = '0;
        in_kv = '0; rTop = '0; rBot = '0; next_ready = 1'b1;
        // children listed from index 3 down to index 0
        bot_caps  = {mk(0, 1, 0), mk(0, 3, 0), mk(0, 3, 0), mk(0, 2, 0)};
        bot_deq   = {mk(1, 1, kv(16'h20)), mk(0, 1, kv(16'h38)), mk(1, 1, kv(16'h38)), mk(1, 1, kv(16'h10))};
        bot_deq2  = {mk(0, 1, kv(16'h99)), mk(1, 1, kv(16'h22)), mk(1, 1, kv(16'h11)), mk(0, 1, kv(16'h90))};
        bot_empty = {mk(0, 2, 0), mk(0, 2, 0), mk(0, 2, 0), mk(0, 2, 0)};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst ready", mx_ready, 1);
        chk("rst active", mx_active, 0);
        chk("rst done", mx_done, 0);
        chk("rst wen", mx_wen, 0);
        chk("rst wData", mx_wdata, 0);
        chk("rst out_kv", mx_out_kv, 0);
        chk("rst out_op", mx_out_op, 0);
        chk("rst endPos", mx_end_pos, 0);
        chk("rst ovf", mx_ovf, 0);
        chk("rst udf", mx_udf, 0);
        rst = 1'b0;

        // NOP start is ignored
        @(negedge clk);
        start_mx = 1'b1; op = 2'b00;
        #1 chk("nop done", mx_done, 0);
        @(negedge clk);
        start_mx = 1'b0;
        chk("nop ready", mx_ready, 1);

        run_op("enq_empty", 0, 2'b01, 2'd1, kv(16'h30), mk(0, 5, 0), bot_caps,
               ex(1, mk(1, 4, kv(16'h30)), 0, 0, 2'b00, 0, 0, 0));
        run_op("enq_fwd", 0, 2'b01, 2'd1, kv(16'h50), mk(1, 4, kv(16'h40)), bot_caps,
               ex(1, mk(1, 3, kv(16'h50)), 0, 0, 2'b01, 4'b0101, 1, kv(16'h40)));
        wait_idle("enq_fwd", 0);
        run_op("enq_tie", 0, 2'b01, 2'd2, {16'h40, 16'hBEEF}, mk(1, 4, kv(16'h40)), bot_caps,
               ex(1, mk(1, 3, kv(16'h40)), 0, 0, 2'b01, 4'b1001, 1, {16'h40, 16'hBEEF}));
        wait_idle("enq_tie", 0);
        run_op("deq_fwd", 0, 2'b10, 2'd1, 0, mk(1, 2, kv(16'h40)), bot_deq,
               ex(1, mk(1, 3, kv(16'h38)), 0, 0, 2'b10, 4'b0101, 1, kv(16'h40)));
        wait_idle("deq_fwd", 0);
        run_op("deq_sat", 0, 2'b10, 2'd3, 0, mk(1, 8'hFF, kv(16'h40)), bot_deq2,
               ex(1, mk(1, 8'hFF, kv(16'h22)), 0, 0, 2'b10, 4'b1110, 1, kv(16'h40)));
        wait_idle("deq_sat", 0);
        run_op("deq_leaf", 0, 2'b10, 2'd1, 0, mk(1, 6, kv(16'h40)), bot_empty,
               ex(1, mk(0, 7, 0), 0, 0, 2'b00, 0, 1, kv(16'h40)));
        run_op("rep_fwd", 0, 2'b11, 2'd1, kv(16'h20), mk(1, 4, kv(16'h40)), bot_deq,
               ex(1, mk(1, 4, kv(16'h38)), 0, 0, 2'b11, 4'b0101, 1, kv(16'h40)));
        wait_idle("rep_fwd", 0);
        run_op("rep_stay", 0, 2'b11, 2'd1, kv(16'h60), mk(1, 4, kv(16'h40)), bot_deq,
               ex(1, mk(1, 4, kv(16'h60)), 0, 0, 2'b00, 0, 1, kv(16'h40)));
        run_op("rep_tie", 0, 2'b11, 2'd1, {16'h38, 16'hBEEF}, mk(1, 4, kv(16'h40)), bot_deq,
               ex(1, mk(1, 4, {16'h38, 16'hBEEF}), 0, 0, 2'b00, 0, 1, kv(16'h40)));
        run_op("rep_empty", 0, 2'b11, 2'd0, kv(16'h20), mk(0, 5, 0), bot_deq,
               ex(1, mk(1, 4, kv(16'h20)), 0, 0, 2'b00, 0, 0, 0));
        run_op("ovf", 0, 2'b01, 2'd1, kv(16'h30), mk(1, 0, kv(16'h40)), bot_caps,
               ex(0, 0, 1, 0, 2'b00, 0, 1, kv(16'h30)));
        run_op("udf", 0, 2'b10, 2'd1, 0, mk(0, 3, 0), bot_deq,
               ex(0, 0, 0, 1, 2'b00, 0, 1, 0));

        // Min-heap ordering
        run_op("min_rep_fwd", 1, 2'b11, 2'd1, kv(16'h20), mk(1, 4, kv(16'h40)), bot_deq,
               ex(1, mk(1, 4, kv(16'h10)), 0, 0, 2'b11, 4'b0100, 1, kv(16'h40)));
        wait_idle("min_rep_fwd", 1);
        run_op("min_rep_stay", 1, 2'b11, 2'd1, kv(16'h05), mk(1, 4, kv(16'h40)), bot_deq,
               ex(1, mk(1, 4, kv(16'h05)), 0, 0, 2'b00, 0, 1, kv(16'h40)));
        run_op("min_enq", 1, 2'b01, 2'd1, kv(16'h50), mk(1, 4, kv(16'h40)), bot_caps,
               ex(1, mk(1, 3, kv(16'h40)), 0, 0, 2'b01, 4'b0101, 1, kv(16'h50)));
        wait_idle("min_enq", 1);
        run_op("min_deq", 1, 2'b10, 2'd1, 0, mk(1, 2, kv(16'h40)), bot_deq2,
               ex(1, mk(1, 3, kv(16'h11)), 0, 0, 2'b10, 4'b0101, 1, kv(16'h40)));
        wait_idle("min_deq", 1);

        // Downstream stall: SEND holds with stable payload and ignores start
        next_ready = 1'b0;
        run_op("stall", 0, 2'b01, 2'd1, kv(16'h50), mk(1, 4, kv(16'h40)), bot_caps,
               ex(1, mk(1, 3, kv(16'h50)), 0, 0, 2'b01, 4'b0101, 1, kv(16'h40)));
        held_kv = mx_out_kv;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start_mx = 1'b1; op = 2'b10; startPos = 2'd2;
            #1;
            chk("stall done", mx_done, 2'b10);
            chk("stall out_kv", mx_out_kv, kv(16'h40));
            chk("stall out_op", mx_out_op, 2'b01);
            chk("stall endPos", mx_end_pos, 4'b0101);
            chk("stall wen", mx_wen, 0);
            chk("stall ready", mx_ready, 0);
            $display("stall cycle %0d: done=%0d out_kv=%h", i, mx_done, mx_out_kv);
        end
        @(negedge clk);
        start_mx = 1'b0; next_ready = 1'b1;
        @(negedge clk);
        chk("stall handoff ready", mx_ready, 1);
        chk("stall kv held", mx_out_kv, held_kv);

        // Reset during EVAL: write suppressed, back to IDLE
        @(negedge clk);
        start_mx = 1'b1; op = 2'b01; startPos = 2'd1; in_kv = kv(16'h30); rTop = mk(0, 5, 0);
        @(negedge clk);
        start_mx = 1'b0;
        rst = 1'b1;
        #1 chk("rst_eval wen", mx_wen, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_eval ready", mx_ready, 1);
        chk("rst_eval done", mx_done, 0);
        $display("op rst_eval: ready=%0d", mx_ready);

        // Reset during SEND: forwarded op dropped
        next_ready = 1'b0;
        run_op("rst_send", 0, 2'b01, 2'd1, kv(16'h50), mk(1, 4, kv(16'h40)), bot_caps,
               ex(1, mk(1, 3, kv(16'h50)), 0, 0, 2'b01, 4'b0101, 1, kv(16'h40)));
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rst_send wen", mx_wen, 0);
        @(negedge clk);
        rst = 1'b0; next_ready = 1'b1;
        chk("rst_send ready", mx_ready, 1);
        chk("rst_send out_op", mx_out_op, 0);
        chk("rst_send out_kv", mx_out_kv, 0);
        chk("rst_send endPos", mx_end_pos, 0);
        chk("rst_send done", mx_done, 0);
        $display("op rst_send: ready=%0d out_op=%0d", mx_ready, mx_out_op);

        chk("scoreboard empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running required finished");
        $fatal(1, "timeout");
    end

endmodule
